// File: rtl/ms_riscv32_mp_bus_pkg.sv
// Shared types for the fetch/data bus arbiter: bus transfer codes, FSM states, owner IDs.
package ms_riscv32_mp_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Bit positions inside the grant vector
  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_DM = 1;
  localparam int unsigned GNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/ms_riscv32_mp_arb_prio.sv
// Combinational grant select between fetch and data requesters.
// MS_RISCV32_MP_ARB_FAIRNESS_EN adds a saturating data-burst counter that forces a fetch turn.
module ms_riscv32_mp_arb_prio
  import ms_riscv32_mp_bus_pkg::*;
#(
  parameter int unsigned MAX_DM_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic             dm_req,
  input  logic             gnt_en,
  output logic [GNT_W-1:0] gnt_c
);

`ifdef MS_RISCV32_MP_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = $clog2(MAX_DM_BURST + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_turn_c;

  always_comb begin
    fetch_turn_c = (cnt_q == CNT_W'(MAX_DM_BURST)) && if_req;
    gnt_c        = '0;
    cnt_d        = cnt_q;
    if (gnt_en) begin
      if (dm_req && !fetch_turn_c) begin
        gnt_c[GNT_DM] = 1'b1;
      end else if (if_req) begin
        gnt_c[GNT_IF] = 1'b1;
      end
    end
    // Consecutive data grants saturate; any fetch grant restarts the count
    if (gnt_c[GNT_IF]) begin
      cnt_d = '0;
    end else if (gnt_c[GNT_DM] && (cnt_q != CNT_W'(MAX_DM_BURST))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = clk ^ rst ^ (MAX_DM_BURST == 0);

  always_comb begin
    gnt_c = '0;
    if (gnt_en) begin
      if (dm_req) begin
        gnt_c[GNT_DM] = 1'b1;
      end else if (if_req) begin
        gnt_c[GNT_IF] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ms_riscv32_mp_bus_arbiter.sv
// Shares one AHB-lite style port between instruction fetch and data memory, one transfer at a time.
// Optional fetch fairness is enabled with MS_RISCV32_MP_ARB_FAIRNESS_EN.
module ms_riscv32_mp_bus_arbiter
  import ms_riscv32_mp_bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DM_BURST = 4
) (
  input  logic                ms_riscv32_mp_clk_in,
  input  logic                ms_riscv32_mp_rst_in,
  input  logic                if_req_in,
  input  logic [ADDR_W-1:0]   if_addr_in,
  output logic                if_gnt_out,
  output logic [DATA_W-1:0]   if_rdata_out,
  output logic                if_rvalid_out,
  output logic                if_err_out,
  input  logic                dm_req_in,
  input  logic [ADDR_W-1:0]   dm_addr_in,
  input  logic                dm_we_in,
  input  logic [DATA_W-1:0]   dm_wdata_in,
  input  logic [DATA_W/8-1:0] dm_mask_in,
  output logic                dm_gnt_out,
  output logic [DATA_W-1:0]   dm_rdata_out,
  output logic                dm_rvalid_out,
  output logic                dm_err_out,
  output logic [ADDR_W-1:0]   bus_haddr_out,
  output logic [1:0]          bus_htrans_out,
  output logic                bus_hwrite_out,
  output logic [DATA_W-1:0]   bus_hwdata_out,
  output logic [DATA_W/8-1:0] bus_hmask_out,
  input  logic [DATA_W-1:0]   bus_hrdata_in,
  input  logic                bus_hready_in,
  input  logic                bus_hresp_in
);

  localparam int unsigned MASK_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [MASK_W-1:0] hmask_q, hmask_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic              if_err_q, if_err_d, dm_err_q, dm_err_d;
  logic [GNT_W-1:0]  gnt_c;
  logic              gnt_en_c;

  // Grants only from IDLE, and never while reset is being applied
  assign gnt_en_c = (state_q == IDLE) && !ms_riscv32_mp_rst_in;

  ms_riscv32_mp_arb_prio #(
    .MAX_DM_BURST (MAX_DM_BURST)
  ) u_prio (
    .clk    (ms_riscv32_mp_clk_in),
    .rst    (ms_riscv32_mp_rst_in),
    .if_req (if_req_in),
    .dm_req (dm_req_in),
    .gnt_en (gnt_en_c),
    .gnt_c  (gnt_c)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    hmask_d     = hmask_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    dm_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_c[GNT_DM]) begin
          state_d  = ADDR;
          owner_d  = OWN_DM;
          haddr_d  = dm_addr_in;
          hwrite_d = dm_we_in;
          hwdata_d = dm_wdata_in;
          hmask_d  = dm_mask_in;
          htrans_d = HTRANS_NONSEQ;
        end else if (gnt_c[GNT_IF]) begin
          state_d  = ADDR;
          owner_d  = OWN_IF;
          haddr_d  = if_addr_in;
          hwrite_d = 1'b0;
          hwdata_d = '0;
          hmask_d  = '1;
          htrans_d = HTRANS_NONSEQ;
        end
      end
      ADDR: begin
        if (bus_hready_in) begin
          state_d  = DATA;
          htrans_d = HTRANS_IDLE;
        end
      end
      DATA: begin
        // Completion, including error responses, returns to the owner only
        if (bus_hready_in) begin
          state_d = IDLE;
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            dm_err_d    = bus_hresp_in;
            if (!hwrite_q) begin
              dm_rdata_d = bus_hrdata_in;
            end
          end else begin
            if_rvalid_d = 1'b1;
            if_err_d    = bus_hresp_in;
            if_rdata_d  = bus_hrdata_in;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      hmask_q     <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      hmask_q     <= hmask_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_err_q    <= if_err_d;
      dm_err_q    <= dm_err_d;
    end
  end

  assign if_gnt_out     = gnt_c[GNT_IF];
  assign dm_gnt_out     = gnt_c[GNT_DM];
  assign if_rdata_out   = if_rdata_q;
  assign if_rvalid_out  = if_rvalid_q;
  assign if_err_out     = if_err_q;
  assign dm_rdata_out   = dm_rdata_q;
  assign dm_rvalid_out  = dm_rvalid_q;
  assign dm_err_out     = dm_err_q;
  assign bus_haddr_out  = haddr_q;
  assign bus_htrans_out = htrans_q;
  assign bus_hwrite_out = hwrite_q;
  assign bus_hwdata_out = hwdata_q;
  assign bus_hmask_out  = hmask_q;

endmodule

// File: tb/tb_ms_riscv32_mp_bus_arbiter.sv
// Self-checking bench for ms_riscv32_mp_bus_arbiter: directed vector table, hand sequences and a
// randomized run against a transaction-level model. Honours MS_RISCV32_MP_ARB_FAIRNESS_EN.
module tb_ms_riscv32_mp_bus_arbiter;

`ifdef MS_RISCV32_MP_ARB_FAIRNESS_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_in, if_gnt_out, if_rvalid_out, if_err_out;
  logic [31:0] if_addr_in, if_rdata_out;
  logic        dm_req_in, dm_we_in, dm_gnt_out, dm_rvalid_out, dm_err_out;
  logic [31:0] dm_addr_in, dm_wdata_in, dm_rdata_out;
  logic [3:0]  dm_mask_in, bus_hmask_out;
  logic [31:0] bus_haddr_out, bus_hwdata_out, bus_hrdata_in;
  logic [1:0]  bus_htrans_out;
  logic        bus_hwrite_out, bus_hready_in, bus_hresp_in;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ms_riscv32_mp_bus_arbiter dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .if_req_in      (if_req_in),
    .if_addr_in     (if_addr_in),
    .if_gnt_out     (if_gnt_out),
    .if_rdata_out   (if_rdata_out),
    .if_rvalid_out  (if_rvalid_out),
    .if_err_out     (if_err_out),
    .dm_req_in      (dm_req_in),
    .dm_addr_in     (dm_addr_in),
    .dm_we_in       (dm_we_in),
    .dm_wdata_in    (dm_wdata_in),
    .dm_mask_in     (dm_mask_in),
    .dm_gnt_out     (dm_gnt_out),
    .dm_rdata_out   (dm_rdata_out),
    .dm_rvalid_out  (dm_rvalid_out),
    .dm_err_out     (dm_err_out),
    .bus_haddr_out  (bus_haddr_out),
    .bus_htrans_out (bus_htrans_out),
    .bus_hwrite_out (bus_hwrite_out),
    .bus_hwdata_out (bus_hwdata_out),
    .bus_hmask_out  (bus_hmask_out),
    .bus_hrdata_in  (bus_hrdata_in),
    .bus_hready_in  (bus_hready_in),
    .bus_hresp_in   (bus_hresp_in)
  );

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] hrdata;
    int          aw;
    int          dw;
    logic        resp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req_in = 1'b0;
    dm_req_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated transfer; the bench paces hready from the vector's wait-state counts.
  task automatic run_vec(input int idx, input vec_t v);
    logic own_rv, oth_rv, own_err;
    logic [31:0] own_rd;
    if_req_in     = !v.is_dm;
    if_addr_in    = v.addr;
    dm_req_in     = v.is_dm;
    dm_addr_in    = v.addr;
    dm_we_in      = v.we;
    dm_wdata_in   = v.wdata;
    dm_mask_in    = v.mask;
    bus_hready_in = 1'b1;
    bus_hresp_in  = 1'b0;
    bus_hrdata_in = v.hrdata;
    #1;
    chk($sformatf("v%0d_gnt", idx), 32'({dm_gnt_out, if_gnt_out}), v.is_dm ? 32'd2 : 32'd1);
    for (int k = 1; k <= v.exp_lat; k++) begin
      tick();
      if_req_in = 1'b0;
      dm_req_in = 1'b0;
      if (k <= v.aw + 1) begin
        chk($sformatf("v%0d_htrans_k%0d", idx, k), 32'(bus_htrans_out), 32'h2);
        chk($sformatf("v%0d_haddr_k%0d", idx, k), bus_haddr_out, v.addr);
        chk($sformatf("v%0d_hwrite_k%0d", idx, k), 32'(bus_hwrite_out), 32'(v.we));
      end else if (k < v.exp_lat) begin
        chk($sformatf("v%0d_htrans_k%0d", idx, k), 32'(bus_htrans_out), 32'h0);
        if (v.we) chk($sformatf("v%0d_hwdata_k%0d", idx, k), bus_hwdata_out, v.wdata);
      end
      own_rv  = v.is_dm ? dm_rvalid_out : if_rvalid_out;
      oth_rv  = v.is_dm ? if_rvalid_out : dm_rvalid_out;
      own_err = v.is_dm ? dm_err_out : if_err_out;
      own_rd  = v.is_dm ? dm_rdata_out : if_rdata_out;
      chk($sformatf("v%0d_rvalid_k%0d", idx, k), 32'(own_rv), 32'(k == v.exp_lat));
      chk($sformatf("v%0d_other_rvalid_k%0d", idx, k), 32'(oth_rv), 32'h0);
      if (k == v.exp_lat) begin
        chk($sformatf("v%0d_rdata", idx), own_rd, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), 32'(own_err), 32'(v.exp_err));
      end
      bus_hready_in = (k == v.aw + 1) || (k == v.aw + v.dw + 2);
      bus_hresp_in  = v.resp && (k == v.aw + v.dw + 2);
    end
  endtask

  initial begin
    logic [1:0]  order [6];
    logic [1:0]  exp_order [6];
    int          ng;
    vec_t        rv;
    // random-test model state
    logic        busy, rv_next, addr_next, own, own_we, if_pend, dm_pend, dm_w, rv_err;
    logic [31:0] if_a, dm_a, dm_wd, exp_addr;
    logic [3:0]  dm_m;
    logic [31:0] last_rd [2];
    logic [1:0]  exp_g;
    int          hr_cnt, fair_cnt, rv_side;

    // --- vector table: {is_dm, we, addr, wdata, mask, hrdata, aw, dw, resp, exp_rdata, exp_err, exp_lat}
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678, 0, 0, 1'b0, 32'h1234_5678, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 32'hCAFE_F00D, 2, 3, 1'b0, 32'hCAFE_F00D, 1'b0, 8};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 0, 1'b1, 32'hDEAD_BEEF, 1'b1, 3};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_2000, 32'hAABB_CCDD, 4'hF, 32'h5555_5555, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0BAD_C0DE, 1, 0, 1'b1, 32'h0BAD_C0DE, 1'b1, 4};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_2004, 32'h1122_3344, 4'h3, 32'h6666_6666, 0, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, 5};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 32'h1357_9BDF, 3, 1, 1'b0, 32'h1357_9BDF, 1'b0, 7};

    // --- reset state, with both requests raised so the grant gating is visible
    rst = 1'b1;
    if_req_in = 1'b1; dm_req_in = 1'b1;
    if_addr_in = 32'h0; dm_addr_in = 32'h0; dm_we_in = 1'b0; dm_wdata_in = 32'h0; dm_mask_in = 4'h0;
    bus_hrdata_in = 32'h0; bus_hready_in = 1'b1; bus_hresp_in = 1'b0;
    tick();
    tick();
    chk("rst_htrans", 32'(bus_htrans_out), 32'h0);
    chk("rst_hwrite", 32'(bus_hwrite_out), 32'h0);
    chk("rst_haddr", bus_haddr_out, 32'h0);
    chk("rst_hwdata", bus_hwdata_out, 32'h0);
    chk("rst_hmask", 32'(bus_hmask_out), 32'h0);
    chk("rst_rvalid", 32'({if_rvalid_out, dm_rvalid_out, if_err_out, dm_err_out}), 32'h0);
    chk("rst_rdata", if_rdata_out | dm_rdata_out, 32'h0);
    chk("rst_gnt", 32'({if_gnt_out, dm_gnt_out}), 32'h0);
    rst = 1'b0;
    if_req_in = 1'b0; dm_req_in = 1'b0;
    tick();

    // --- directed vectors: fetch read, wait states, error, write
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // --- simultaneous requests: data write first, fetch exactly 3 cycles later
    if_req_in = 1'b1; if_addr_in = 32'h0000_0180;
    dm_req_in = 1'b1; dm_addr_in = 32'h0000_2000; dm_we_in = 1'b1;
    dm_wdata_in = 32'hAABB_CCDD; dm_mask_in = 4'hF;
    bus_hready_in = 1'b1; bus_hresp_in = 1'b0; bus_hrdata_in = 32'h2468_2468;
    #1;
    chk("sim_gnt_T", 32'({dm_gnt_out, if_gnt_out}), 32'd2);
    tick();
    dm_req_in = 1'b0;
    chk("sim_htrans_1", 32'(bus_htrans_out), 32'h2);
    chk("sim_hwrite_1", 32'(bus_hwrite_out), 32'h1);
    chk("sim_haddr_1", bus_haddr_out, 32'h0000_2000);
    #1;
    chk("sim_if_gnt_1", 32'(if_gnt_out), 32'h0);
    tick();
    chk("sim_htrans_2", 32'(bus_htrans_out), 32'h0);
    chk("sim_hwdata_2", bus_hwdata_out, 32'hAABB_CCDD);
    chk("sim_hmask_2", 32'(bus_hmask_out), 32'hF);
    #1;
    chk("sim_if_gnt_2", 32'(if_gnt_out), 32'h0);
    tick();
    chk("sim_dm_rvalid_3", 32'(dm_rvalid_out), 32'h1);
    #1;
    chk("sim_if_gnt_3", 32'({dm_gnt_out, if_gnt_out}), 32'd1);
    tick();
    if_req_in = 1'b0;
    chk("sim_if_haddr_4", bus_haddr_out, 32'h0000_0180);
    chk("sim_if_hwrite_4", 32'(bus_hwrite_out), 32'h0);
    tick();
    tick();
    chk("sim_if_rvalid_6", 32'(if_rvalid_out), 32'h1);
    chk("sim_if_rdata_6", if_rdata_out, 32'h2468_2468);

    // --- reset during the data phase, with a completing hready on the same edge
    dm_req_in = 1'b1; dm_addr_in = 32'h0000_0300; dm_we_in = 1'b0;
    bus_hready_in = 1'b1; bus_hrdata_in = 32'h7777_7777;
    #1;
    chk("rmid_gnt", 32'(dm_gnt_out), 32'h1);
    tick();
    dm_req_in = 1'b0;
    chk("rmid_htrans_addr", 32'(bus_htrans_out), 32'h2);
    tick();
    rst = 1'b1;
    dm_req_in = 1'b1;
    tick();
    chk("rmid_htrans", 32'(bus_htrans_out), 32'h0);
    chk("rmid_rvalid", 32'({if_rvalid_out, dm_rvalid_out}), 32'h0);
    #1;
    chk("rmid_gnt_in_rst", 32'({if_gnt_out, dm_gnt_out}), 32'h0);
    tick();
    rst = 1'b0;
    rv = '{1'b1, 1'b0, 32'h0000_0308, 32'h0, 4'hF, 32'h0F0F_0F0F, 0, 0, 1'b0, 32'h0F0F_0F0F, 1'b0, 3};
    run_vec(7, rv);

    // --- fairness: both requesters held high
    do_reset();
    if_req_in = 1'b1; dm_req_in = 1'b1; dm_we_in = 1'b0;
    bus_hready_in = 1'b1; bus_hresp_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      order[i] = 2'd3;
      exp_order[i] = (FAIR_EN && i == 4) ? 2'd1 : 2'd2;
    end
    ng = 0;
    for (int cyc = 0; cyc < 60 && ng < 6; cyc++) begin
      #1;
      if (dm_gnt_out) begin order[ng] = 2'd2; ng++; end
      else if (if_gnt_out) begin order[ng] = 2'd1; ng++; end
      tick();
    end
    for (int i = 0; i < 6; i++) chk($sformatf("fair_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // --- randomized traffic against a transaction-level model
    do_reset();
    busy = 1'b0; rv_next = 1'b0; addr_next = 1'b0; if_pend = 1'b0; dm_pend = 1'b0;
    own = 1'b0; own_we = 1'b0; rv_err = 1'b0; dm_w = 1'b0; exp_addr = 32'h0;
    if_a = 32'h0; dm_a = 32'h0; dm_wd = 32'h0; dm_m = 4'h0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    hr_cnt = 0; fair_cnt = 0; rv_side = 0;
    for (int c = 0; c < 800; c++) begin
      tick();
      chk("rnd_if_rvalid", 32'(if_rvalid_out), 32'(rv_next && rv_side == 0));
      chk("rnd_dm_rvalid", 32'(dm_rvalid_out), 32'(rv_next && rv_side == 1));
      if (rv_next) begin
        chk("rnd_rdata", rv_side == 1 ? dm_rdata_out : if_rdata_out, last_rd[rv_side]);
        chk("rnd_err", 32'(rv_side == 1 ? dm_err_out : if_err_out), 32'(rv_err));
      end
      if (addr_next) begin
        chk("rnd_htrans", 32'(bus_htrans_out), 32'h2);
        chk("rnd_haddr", bus_haddr_out, exp_addr);
        chk("rnd_hwrite", 32'(bus_hwrite_out), 32'(own_we));
      end
      rv_next = 1'b0;
      addr_next = 1'b0;
      if (!if_pend && $urandom_range(2) == 0) begin
        if_pend = 1'b1; if_a = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_pend && $urandom_range(2) == 0) begin
        dm_pend = 1'b1; dm_a = $urandom; dm_w = 1'($urandom_range(1));
        dm_wd = $urandom; dm_m = 4'($urandom);
      end
      if_req_in = if_pend; if_addr_in = if_a;
      dm_req_in = dm_pend; dm_addr_in = dm_a; dm_we_in = dm_w; dm_wdata_in = dm_wd; dm_mask_in = dm_m;
      bus_hready_in = ($urandom_range(3) != 0);
      bus_hresp_in  = ($urandom_range(7) == 0);
      bus_hrdata_in = $urandom;
      #1;
      exp_g = 2'b00;
      if (!busy) begin
        if (dm_pend && !(FAIR_EN && fair_cnt == MAXB && if_pend)) exp_g = 2'b10;
        else if (if_pend) exp_g = 2'b01;
      end
      chk("rnd_gnt", 32'({dm_gnt_out, if_gnt_out}), 32'(exp_g));
      if (exp_g != 2'b00) begin
        busy = 1'b1; hr_cnt = 0; addr_next = 1'b1;
        own = exp_g[1];
        own_we = exp_g[1] ? dm_w : 1'b0;
        exp_addr = exp_g[1] ? dm_a : if_a;
        if (exp_g[1]) begin
          dm_pend = 1'b0;
          fair_cnt = (fair_cnt < MAXB) ? fair_cnt + 1 : MAXB;
        end else begin
          if_pend = 1'b0;
          fair_cnt = 0;
        end
      end else if (busy && bus_hready_in) begin
        // second hready after a grant ends the data phase
        hr_cnt++;
        if (hr_cnt == 2) begin
          rv_next = 1'b1; rv_side = int'(own); rv_err = bus_hresp_in;
          if (!own_we) last_rd[int'(own)] = bus_hrdata_in;
          busy = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
